// File: rtl/instr_fetch_unit.sv
// Multicycle instruction-fetch stage: owns the PC, fetches one word over a
// req/ack handshake with a bounded wait, and presents the decoded IR fields.
module instr_fetch_unit #(
  parameter int          I_ADDR_BITS = 8,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_start,
  input  logic                   pc_src,
  input  logic [63:0]            pc_target,
  output logic                   i_mem_req,
  output logic [I_ADDR_BITS-1:0] i_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [31:0]            i_mem_data,
  output logic [31:0]            instr,
  output logic [6:0]             opcode,
  output logic [4:0]             rd,
  output logic [2:0]             funct3,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [6:0]             funct7,
  output logic [63:0]            pc,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   misalign,
  output logic                   fetch_err
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      state_reg, state_next;
  logic [31:0] instr_reg, instr_next;
  logic [63:0] pc_reg, pc_next;
  logic [63:0] fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic        first_reg, first_next;
  logic        valid_reg, valid_next;
  logic        misalign_reg, misalign_next;
  logic        err_reg, err_next;
  logic [63:0] nxt_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      instr_reg    <= 32'h0;
      pc_reg       <= RESET_PC;
      fetch_pc_reg <= RESET_PC;
      cnt_reg      <= '0;
      first_reg    <= 1'b1;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      instr_reg    <= instr_next;
      pc_reg       <= pc_next;
      fetch_pc_reg <= fetch_pc_next;
      cnt_reg      <= cnt_next;
      first_reg    <= first_next;
      valid_reg    <= valid_next;
      misalign_reg <= misalign_next;
      err_reg      <= err_next;
    end
  end

  // First fetch after reset always targets RESET_PC regardless of pc_src.
  assign nxt_pc = first_reg ? RESET_PC : (pc_src ? pc_target : pc_reg + 64'd4);

  always_comb begin
    state_next    = state_reg;
    instr_next    = instr_reg;
    pc_next       = pc_reg;
    fetch_pc_next = fetch_pc_reg;
    cnt_next      = cnt_reg;
    first_next    = first_reg;
    valid_next    = valid_reg;
    misalign_next = misalign_reg;
    err_next      = err_reg;
    case (state_reg)
      IDLE: begin
        if (fetch_start) begin
          valid_next    = 1'b0;
          misalign_next = 1'b0;
          err_next      = 1'b0;
          if (nxt_pc[1:0] != 2'b00) begin
            misalign_next = 1'b1;
          end else begin
            fetch_pc_next = nxt_pc;
            cnt_next      = '0;
            state_next    = FETCH;
          end
        end
      end
      FETCH: begin
        // Ack wins over timeout on the final wait cycle.
        if (i_mem_ack) begin
          instr_next = i_mem_data;
          pc_next    = fetch_pc_reg;
          first_next = 1'b0;
          valid_next = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign i_mem_req   = (state_reg == FETCH);
  assign busy        = (state_reg == FETCH);
  assign i_mem_addr  = fetch_pc_reg[I_ADDR_BITS-1:0];
  assign instr       = instr_reg;
  assign pc          = pc_reg;
  assign instr_valid = valid_reg;
  assign misalign    = misalign_reg;
  assign fetch_err   = err_reg;

  assign opcode = instr_reg[6:0];
  assign rd     = instr_reg[11:7];
  assign funct3 = instr_reg[14:12];
  assign rs1    = instr_reg[19:15];
  assign rs2    = instr_reg[24:20];
  assign funct7 = instr_reg[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: inputs driven and outputs sampled on
// the falling clock edge; expected values are hand-computed constants.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start, pc_src, i_mem_ack;
  logic [63:0] pc_target;
  logic [31:0] i_mem_data;
  logic        i_mem_req;
  logic [7:0]  i_mem_addr;
  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [63:0] pc;
  logic        instr_valid, busy, misalign, fetch_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.I_ADDR_BITS(8), .RESET_PC(64'h0), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_src(pc_src),
    .pc_target(pc_target), .i_mem_req(i_mem_req), .i_mem_addr(i_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data), .instr(instr), .opcode(opcode),
    .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .pc(pc),
    .instr_valid(instr_valid), .busy(busy), .misalign(misalign), .fetch_err(fetch_err)
  );

  task automatic do_reset();
    rst_n = 1'b0; fetch_start = 1'b0; pc_src = 1'b0; pc_target = '0;
    i_mem_ack = 1'b0; i_mem_data = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issues one fetch and acks on wait cycle waits+1 (waits<0: never ack).
  task automatic run_fetch(input logic src, input logic [63:0] tgt, input int waits,
                           input logic [31:0] data, output int cycles, output logic [7:0] addr);
    fetch_start = 1'b1; pc_src = src; pc_target = tgt;
    @(negedge clk);
    fetch_start = 1'b0;
    cycles = 0;
    addr = i_mem_addr;
    while (busy && cycles < 40) begin
      cycles++;
      addr = i_mem_addr;
      checks++;
      if (i_mem_req !== 1'b1) begin
        errors++;
        $display("FAIL req_during_busy: i_mem_req=%b required 1", i_mem_req);
      end
      i_mem_ack  = (waits >= 0) && (cycles == waits + 1);
      i_mem_data = data;
      @(negedge clk);
    end
    i_mem_ack = 1'b0;
    $display("fetch: src=%0d tgt=%h addr=%h cycles=%0d pc=%h instr=%h valid=%b err=%b",
             src, tgt, addr, cycles, pc, instr, instr_valid, fetch_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_start = 1'b0; pc_src = 1'b0; pc_target = '0;
    i_mem_ack = 1'b0; i_mem_data = '0;
    @(negedge clk);
    checks++;
    if ({i_mem_req, instr_valid, busy, misalign, fetch_err} !== 5'b0 ||
        instr !== 32'h0 || pc !== 64'h0) begin
      errors++;
      $display("FAIL reset: req/valid/busy/mis/err=%b instr=%h pc=%h required 0/0/0",
               {i_mem_req, instr_valid, busy, misalign, fetch_err}, instr, pc);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_first_fetch();
    fetch_start = 1'b1; pc_src = 1'b1; pc_target = 64'h80;
    @(negedge clk);
    fetch_start = 1'b0;
    checks++;
    if (i_mem_req !== 1'b1 || i_mem_addr !== 8'h00 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h valid=%b required 1/00/0",
               i_mem_req, i_mem_addr, instr_valid);
    end
    i_mem_ack = 1'b1; i_mem_data = 32'h00A00093;
    @(negedge clk);
    i_mem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00A00093 || opcode !== 7'h13 ||
        rd !== 5'd1 || rs1 !== 5'd0 || pc !== 64'h0 || i_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch: valid=%b instr=%h op=%h rd=%0d rs1=%0d pc=%h req=%b required 1/00a00093/13/1/0/0/0",
               instr_valid, instr, opcode, rd, rs1, pc, i_mem_req);
    end
    checks++;
    if (funct3 !== 3'd0 || rs2 !== 5'd10 || funct7 !== 7'd0) begin
      errors++;
      $display("FAIL fields: f3=%0d rs2=%0d f7=%0d required 0/10/0", funct3, rs2, funct7);
    end
    $display("first_fetch: instr=%h pc=%h", instr, pc);
  endtask

  task automatic test_sequential();
    logic [31:0] words [3] = '{32'h00100113, 32'h402081B3, 32'h0041A223};
    logic [7:0]  exp_a;
    logic [7:0]  addr;
    int          cyc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_a = 8'(4 * i);
      run_fetch(1'b0, 64'h0, 3, words[i], cyc, addr);
      checks++;
      if (addr !== exp_a || cyc !== 4 || instr !== words[i] ||
          pc !== 64'(4 * i) || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq%0d: addr=%h busy=%0d instr=%h pc=%h valid=%b required %h/4/%h/%0d/1",
                 i, addr, cyc, instr, pc, instr_valid, exp_a, words[i], 4 * i);
      end
    end
    checks++;
    if (funct7 !== 7'h00 || rs2 !== 5'd4 || funct3 !== 3'd2 || opcode !== 7'h23) begin
      errors++;
      $display("FAIL seq_fields: f7=%h rs2=%0d f3=%0d op=%h required 00/4/2/23",
               funct7, rs2, funct3, opcode);
    end
  endtask

  task automatic test_branch_misalign();
    logic [7:0] addr;
    int         cyc;
    run_fetch(1'b1, 64'h40, 0, 32'h00000013, cyc, addr);
    checks++;
    if (addr !== 8'h40 || pc !== 64'h40 || cyc !== 1) begin
      errors++;
      $display("FAIL branch: addr=%h pc=%h cycles=%0d required 40/40/1", addr, pc, cyc);
    end
    fetch_start = 1'b1; pc_src = 1'b1; pc_target = 64'h42;
    @(negedge clk);
    fetch_start = 1'b0;
    checks++;
    if (misalign !== 1'b1 || i_mem_req !== 1'b0 || busy !== 1'b0 ||
        pc !== 64'h40 || instr_valid !== 1'b0 || instr !== 32'h00000013) begin
      errors++;
      $display("FAIL misalign: mis=%b req=%b busy=%b pc=%h valid=%b instr=%h required 1/0/0/40/0/00000013",
               misalign, i_mem_req, busy, pc, instr_valid, instr);
    end
    @(negedge clk);
    checks++;
    if (i_mem_req !== 1'b0 || misalign !== 1'b1) begin
      errors++;
      $display("FAIL misalign_hold: req=%b mis=%b required 0/1", i_mem_req, misalign);
    end
    $display("misalign: tgt=42 mis=%b pc=%h", misalign, pc);
  endtask

  task automatic test_timeout();
    logic [7:0] addr;
    int         cyc;
    run_fetch(1'b0, 64'h0, -1, 32'hDEADBEEF, cyc, addr);
    checks++;
    if (cyc !== 16 || fetch_err !== 1'b1 || instr !== 32'h00000013 ||
        pc !== 64'h40 || instr_valid !== 1'b0 || misalign !== 1'b0 || addr !== 8'h44) begin
      errors++;
      $display("FAIL timeout: cycles=%0d err=%b instr=%h pc=%h valid=%b mis=%b addr=%h required 16/1/00000013/40/0/0/44",
               cyc, fetch_err, instr, pc, instr_valid, misalign, addr);
    end
    run_fetch(1'b0, 64'h0, 15, 32'h00308093, cyc, addr);
    checks++;
    if (cyc !== 16 || fetch_err !== 1'b0 || instr !== 32'h00308093 ||
        pc !== 64'h44 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL last_cycle_ack: cycles=%0d err=%b instr=%h pc=%h valid=%b required 16/0/00308093/44/1",
               cyc, fetch_err, instr, pc, instr_valid);
    end
  endtask

  task automatic test_async_reset();
    fetch_start = 1'b1; pc_src = 1'b0;
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (i_mem_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_req: req=%b required 1", i_mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (i_mem_req !== 1'b0 || busy !== 1'b0 || pc !== 64'h0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: req=%b busy=%b pc=%h instr=%h required 0/0/0/0",
               i_mem_req, busy, pc, instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_mem_ack = 1'b1; i_mem_data = 32'hCAFEF00D;
    @(negedge clk); @(negedge clk);
    i_mem_ack = 1'b0;
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || i_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL late_ack: instr=%h valid=%b req=%b required 0/0/0",
               instr, instr_valid, i_mem_req);
    end
    $display("async_reset: instr=%h valid=%b", instr, instr_valid);
  endtask

  task automatic test_wrap();
    logic [7:0] addr;
    int         cyc;
    run_fetch(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h00000033, cyc, addr);
    checks++;
    if (addr !== 8'h00 || pc !== 64'h0) begin
      errors++;
      $display("FAIL first_after_reset: addr=%h pc=%h required 00/0", addr, pc);
    end
    run_fetch(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h00000073, cyc, addr);
    checks++;
    if (addr !== 8'hFC || pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL top_pc: addr=%h pc=%h required fc/fffffffffffffffc", addr, pc);
    end
    run_fetch(1'b0, 64'h0, 0, 32'h00100073, cyc, addr);
    checks++;
    if (addr !== 8'h00 || pc !== 64'h0 || instr !== 32'h00100073) begin
      errors++;
      $display("FAIL wrap: addr=%h pc=%h instr=%h required 00/0/00100073", addr, pc, instr);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch_misalign();
    test_timeout();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
